// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported synchronous-read memory between the fetch and data
// ports, one access per cycle, with responses one cycle after the grant.
module unified_mem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_done,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              stall_if,
  output logic              m_en,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  logic        r_last_d;
  logic        r_vld_i_p1, r_err_i_p1;
  logic        r_vld_d_p1, r_err_d_p1, r_load_d_p1;
  logic [31:0] r_i_rdata, r_d_rdata;

  logic        w_i_oor, w_d_oor;
  logic        w_i_win, w_d_win;
  logic [31:0] w_i_rdata, w_d_rdata;
  logic        w_unused;

  // Byte-offset bits never reach the word-addressed memory.
  assign w_unused = ^{i_addr[1:0], d_addr[1:0]};

  assign w_i_oor = |i_addr[31:ADDR_W+2];
  assign w_d_oor = |d_addr[31:ADDR_W+2];

  // Data wins a collision unless it won the previous grant.
  always_comb begin
    w_d_win = 1'b0;
    w_i_win = 1'b0;
    if (!reset) begin
      if (d_req && (!i_req || !r_last_d)) begin
        w_d_win = 1'b1;
      end else if (i_req) begin
        w_i_win = 1'b1;
      end
    end
  end

  always_comb begin
    m_en    = 1'b0;
    m_we    = 4'b0000;
    m_addr  = i_addr[ADDR_W+1:2];
    m_wdata = d_wdata;
    if (w_d_win) begin
      m_addr = d_addr[ADDR_W+1:2];
      if (!w_d_oor) begin
        if (d_we) begin
          m_we = d_be;
          m_en = |d_be;
        end else begin
          m_en = 1'b1;
        end
      end
    end else if (w_i_win) begin
      m_en = !w_i_oor;
    end
  end

  assign i_gnt    = w_i_win;
  assign d_gnt    = w_d_win;
  assign stall_if = i_req & ~w_i_win & ~reset;

  // Responses are masked combinationally so a reset cycle never shows a done.
  assign i_done = r_vld_i_p1 & ~reset;
  assign i_err  = r_vld_i_p1 & r_err_i_p1 & ~reset;
  assign d_done = r_vld_d_p1 & ~reset;
  assign d_err  = r_vld_d_p1 & r_err_d_p1 & ~reset;

  always_comb begin
    w_i_rdata = r_i_rdata;
    if (reset) begin
      w_i_rdata = 32'd0;
    end else if (r_vld_i_p1) begin
      w_i_rdata = r_err_i_p1 ? 32'd0 : m_rdata;
    end
  end

  // Stores leave the load data register untouched.
  always_comb begin
    w_d_rdata = r_d_rdata;
    if (reset) begin
      w_d_rdata = 32'd0;
    end else if (r_vld_d_p1 && r_err_d_p1) begin
      w_d_rdata = 32'd0;
    end else if (r_vld_d_p1 && r_load_d_p1) begin
      w_d_rdata = m_rdata;
    end
  end

  assign i_rdata = w_i_rdata;
  assign d_rdata = w_d_rdata;

  // Grant stage -> response stage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_d    <= 1'b0;
      r_vld_i_p1  <= 1'b0;
      r_err_i_p1  <= 1'b0;
      r_vld_d_p1  <= 1'b0;
      r_err_d_p1  <= 1'b0;
      r_load_d_p1 <= 1'b0;
      r_i_rdata   <= 32'd0;
      r_d_rdata   <= 32'd0;
    end else begin
      r_vld_i_p1  <= w_i_win;
      r_err_i_p1  <= w_i_win & w_i_oor;
      r_vld_d_p1  <= w_d_win;
      r_err_d_p1  <= w_d_win & w_d_oor;
      r_load_d_p1 <= w_d_win & ~d_we;
      r_i_rdata   <= w_i_rdata;
      r_d_rdata   <= w_d_rdata;
      if (w_d_win) begin
        r_last_d <= 1'b1;
      end else if (w_i_win) begin
        r_last_d <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus random traffic checked
// every cycle against a transaction-level model with its own copy of memory.
module tb_unified_mem_arbiter;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              reset;
  logic              i_req, d_req, d_we;
  logic [31:0]       i_addr, d_addr, d_wdata;
  logic [3:0]        d_be;
  logic              i_gnt, i_done, i_err, d_gnt, d_done, d_err, stall_if, m_en;
  logic [31:0]       i_rdata, d_rdata, m_wdata;
  logic [3:0]        m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_rdata;

  unified_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .stall_if(stall_if), .m_en(m_en), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] init_word(int k);
    logic [7:0] b;
    b = k[7:0];
    if (k == 4) return 32'hDEADBEEF;
    if (k == 8) return 32'h11223344;
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  // Environment memory driven by the DUT's memory port
  logic [31:0] env_mem [DEPTH];
  initial begin
    for (int k = 0; k < DEPTH; k++) env_mem[k] = init_word(k);
    m_rdata = 32'd0;
  end
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we == 4'b0000) m_rdata <= env_mem[m_addr];
      else for (int b = 0; b < 4; b++)
        if (m_we[b]) env_mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
    end
  end

  // Transaction-level reference model
  logic [31:0] ref_mem [DEPTH];
  logic        last_d = 1'b0;
  logic        pi_v = 1'b0, pi_e = 1'b0, pd_v = 1'b0, pd_e = 1'b0, pd_ld = 1'b0;
  logic [31:0] pi_d = 32'd0, pd_d = 32'd0, hold_i = 32'd0, hold_d = 32'd0;
  logic        g_i = 1'b0, g_d = 1'b0;
  initial for (int k = 0; k < DEPTH; k++) ref_mem[k] = init_word(k);

  always @(negedge clk) begin
    logic        e_ig, e_dg, i_oor, d_oor, e_men;
    logic [3:0]  e_mwe;
    logic [31:0] e_maddr, e_ird, e_drd;
    int          ii, di;
    i_oor = i_addr >= (32'd1 << (ADDR_W + 2));
    d_oor = d_addr >= (32'd1 << (ADDR_W + 2));
    ii = int'((i_addr >> 2) % DEPTH);
    di = int'((d_addr >> 2) % DEPTH);
    e_dg = !reset && d_req && (!i_req || !last_d);
    e_ig = !reset && i_req && !e_dg;
    e_men = 1'b0; e_mwe = 4'b0000; e_maddr = 32'd0;
    if (e_dg) begin
      e_maddr = di;
      if (!d_oor) begin
        e_mwe = d_we ? d_be : 4'b0000;
        e_men = d_we ? (d_be != 4'b0000) : 1'b1;
      end
    end else if (e_ig) begin
      e_maddr = ii;
      e_men   = !i_oor;
    end
    e_ird = reset ? 32'd0 : (pi_v ? pi_d : hold_i);
    e_drd = reset ? 32'd0 : ((pd_v && (pd_e || pd_ld)) ? pd_d : hold_d);
    chk("i_gnt", i_gnt, e_ig);
    chk("d_gnt", d_gnt, e_dg);
    chk("stall_if", stall_if, !reset && i_req && !e_ig);
    chk("m_en", m_en, e_men);
    chk("m_we", m_we, e_mwe);
    if (e_men) chk("m_addr", m_addr, e_maddr);
    if (e_mwe != 0) chk("m_wdata", m_wdata, d_wdata);
    chk("i_done", i_done, !reset && pi_v);
    chk("i_err", i_err, !reset && pi_v && pi_e);
    chk("i_rdata", i_rdata, e_ird);
    chk("d_done", d_done, !reset && pd_v);
    chk("d_err", d_err, !reset && pd_v && pd_e);
    chk("d_rdata", d_rdata, e_drd);
    g_i = e_ig;
    g_d = e_dg;
    if (reset) begin
      last_d = 1'b0; pi_v = 1'b0; pd_v = 1'b0; hold_i = 32'd0; hold_d = 32'd0;
    end else begin
      hold_i = e_ird;
      hold_d = e_drd;
      pi_v = e_ig; pi_e = i_oor; pi_d = i_oor ? 32'd0 : ref_mem[ii];
      pd_v = e_dg; pd_e = d_oor; pd_ld = !d_we; pd_d = d_oor ? 32'd0 : ref_mem[di];
      if (e_dg && d_we && !d_oor)
        for (int b = 0; b < 4; b++)
          if (d_be[b]) ref_mem[di][8*b +: 8] = d_wdata[8*b +: 8];
      if (e_dg) last_d = 1'b1;
      else if (e_ig) last_d = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return $urandom;
    return {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    reset = 1'b1; i_req = 1'b0; i_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'b0000; d_addr = 32'd0; d_wdata = 32'd0;

    // Reset state, then a fetch of 0x10
    @(negedge clk);
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_i_rdata", i_rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    chk("t1_i_gnt", i_gnt, 1);
    chk("t1_m_addr", m_addr, 4);
    chk("t1_m_we", m_we, 0);
    tick(); i_req = 1'b0;
    @(negedge clk);
    chk("t1_i_done", i_done, 1);
    chk("t1_i_rdata", i_rdata, 32'hDEADBEEF);

    // Partial store then load back
    tick(); d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h20; d_wdata = 32'hAABBCCDD;
    @(negedge clk);
    chk("t2_m_we", m_we, 4'b0011);
    chk("t2_m_en", m_en, 1);
    tick(); d_we = 1'b0;
    @(negedge clk);
    chk("t2_st_done", d_done, 1);
    chk("t2_ld_gnt", d_gnt, 1);
    tick(); d_req = 1'b0;
    @(negedge clk);
    chk("t2_ld_done", d_done, 1);
    chk("t2_ld_data", d_rdata, 32'h1122CCDD);

    // Continuous contention from reset alternates D,I,D,I,...
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_addr = 32'h4;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t3_d_gnt", d_gnt, (k % 2) == 0);
      chk("t3_stall", stall_if, (k % 2) == 0);
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;

    // Out-of-range load, then a normal fetch
    tick(); d_req = 1'b1; d_addr = 32'h400;
    @(negedge clk);
    chk("t4_m_en", m_en, 0);
    tick(); d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0;
    @(negedge clk);
    chk("t4_d_err", d_err, 1);
    chk("t4_d_rdata", d_rdata, 0);
    tick(); i_req = 1'b0;
    @(negedge clk);
    chk("t4_i_err", i_err, 0);
    chk("t4_i_rdata", i_rdata, init_word(0));

    // Reset drops an in-flight fetch; reset also clears last_d
    tick(); i_req = 1'b1; i_addr = 32'h8;
    tick(); i_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("t5_i_done_a", i_done, 0);
    tick();
    @(negedge clk);
    chk("t5_i_done_b", i_done, 0);
    chk("t5_i_rdata", i_rdata, 0);
    tick(); reset = 1'b0; d_req = 1'b1; d_addr = 32'hC;
    tick(); d_req = 1'b0; reset = 1'b1;
    tick(); reset = 1'b0; i_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    chk("t5_last_d", d_gnt, 1);
    tick(); d_req = 1'b0;
    tick(); i_req = 1'b0;

    // Back-to-back fetches 0x0..0x1C
    tick();
    for (int j = 0; j < 8; j++) begin
      i_req = 1'b1; i_addr = 32'(4 * j);
      @(negedge clk);
      chk("t6_i_gnt", i_gnt, 1);
      if (j > 0) chk("t6_i_rdata", i_rdata, init_word(j - 1));
      tick();
    end
    i_req = 1'b0;
    @(negedge clk);
    chk("t6_i_rdata_last", i_rdata, init_word(7));
    tick();

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if (!i_req || g_i) begin
        i_req  = $urandom_range(0, 3) != 0;
        i_addr = rand_addr();
      end
      if (!d_req || g_d) begin
        d_req   = $urandom_range(0, 2) != 0;
        d_we    = $urandom_range(0, 1) == 1;
        d_be    = 4'($urandom);
        d_addr  = rand_addr();
        d_wdata = $urandom;
      end
      reset = $urandom_range(0, 99) == 0;
      tick();
    end
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
